// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 encryption core.
//   - aes_state_e : control FSM states (IDLE / ROUND / DONE)
//   - RCON        : round constants, entry 0 unused, entries 1..10 valid
//   - rcon_lookup : safe Rcon read for a 4-bit round counter
//   - xtime       : multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
//   - mix_column  : MixColumns on one 32-bit column {a0,a1,a2,a3}
//   - mix_columns : MixColumns on the full 128-bit state
//   - shift_rows  : ShiftRows on the 128-bit column-major state
// ----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Packed so that RCON[i] is round constant i; index 0 is unused.
  localparam logic [10:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  // Counter values above 10 never reach the key schedule, but keep the
  // lookup total so no out-of-range read is ever generated.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    if (rnd <= 4'd10) r = RCON[rnd];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are {a0,a1,a2,a3} with a0 in the top byte (row 0).
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Byte b = r + 4*c lives at [127-8b -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ----------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box applied independently to NBYTES bytes.
// Ports:
//   data_i : NBYTES input bytes (any order, each byte substituted in place)
//   data_o : substituted bytes, same positions as data_i
// ----------------------------------------------------------------------------
module aes_sbox #(
  parameter int NBYTES = 16
) (
  input  logic [8*NBYTES-1:0] data_i,
  output logic [8*NBYTES-1:0] data_o
);

  // Entry k of the S-box sits at bits [8*(255-k) +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX_TABLE[8*(255 - int'(b)) +: 8];
  endfunction

  for (genvar i = 0; i < NBYTES; i++) begin : g_byte
    assign data_o[8*i +: 8] = sbox_byte(data_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_enc_core.sv
// ----------------------------------------------------------------------------
// aes_enc_core
// Iterative AES-128 encryption: one round per clock with on-the-fly key
// expansion. Accepts one plaintext/key pair in IDLE, runs NUM_ROUNDS rounds,
// then holds the ciphertext on a valid/ready output until it is taken.
// Ports:
//   clk_in    : clock, all state on rising edge
//   rst_in    : asynchronous active-high reset
//   key_in    : 128-bit cipher key, [127:120] is key byte 0
//   data_in   : 128-bit plaintext, [127:120] is byte 0, column-major state
//   valid_in  : plaintext/key valid
//   ready_out : core can accept (high only in IDLE)
//   data_out  : ciphertext in DONE, zero otherwise
//   valid_out : ciphertext valid (DONE)
//   ready_in  : downstream accepts ciphertext
//   busy_out  : high in ROUND or DONE
// ----------------------------------------------------------------------------
import aes_pkg::*;

module aes_enc_core #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [127:0] data_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         busy_out
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] sub_state;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_rk;
  logic         last_round;
  logic [127:0] round_out;

  // Round datapath: SubBytes on the whole state.
  aes_sbox #(.NBYTES(16)) u_sbox_state (
    .data_i (state_q),
    .data_o (sub_state)
  );

  // Key schedule: SubWord(RotWord(w3)).
  assign {w0, w1, w2, w3} = rk_q;
  assign rot_word         = {w3[23:0], w3[31:24]};

  aes_sbox #(.NBYTES(4)) u_sbox_key (
    .data_i (rot_word),
    .data_o (sub_word)
  );

  // Each new word chains on the previous new word, so w3_n is the deepest.
  assign w0_n    = w0 ^ sub_word ^ {rcon_lookup(rnd_q), 24'h000000};
  assign w1_n    = w1 ^ w0_n;
  assign w2_n    = w2 ^ w1_n;
  assign w3_n    = w3 ^ w2_n;
  assign next_rk = {w0_n, w1_n, w2_n, w3_n};

  // The final round skips MixColumns.
  assign shifted    = shift_rows(sub_state);
  assign mixed      = mix_columns(shifted);
  assign last_round = (rnd_q == LAST_RND);
  assign round_out  = (last_round ? shifted : mixed) ^ next_rk;

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      IDLE: begin
        if (valid_in) begin
          state_d = data_in ^ key_in;
          rk_d    = key_in;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        rk_d    = next_rk;
        rnd_d   = rnd_q + 4'd1;
        if (last_round) fsm_d = DONE;
      end
      DONE: begin
        if (ready_in) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

  // Outputs depend on registered state only.
  assign ready_out = (fsm_q == IDLE);
  assign valid_out = (fsm_q == DONE);
  assign busy_out  = (fsm_q != IDLE);
  assign data_out  = (fsm_q == DONE) ? state_q : '0;

endmodule

// File: tb/tb_aes_enc_core.sv
// Directed, table-driven bench for aes_enc_core using known-answer vectors.
module tb_aes_enc_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] keyIn;
  logic [127:0] dataIn;
  logic         validIn;
  logic         readyOut;
  logic [127:0] dataOut;
  logic         validOut;
  logic         readyIn;
  logic         busyOut;

  always #5 clk = ~clk;

  aes_enc_core #(.NUM_ROUNDS(10)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .key_in    (keyIn),
    .data_in   (dataIn),
    .valid_in  (validIn),
    .ready_out (readyOut),
    .data_out  (dataOut),
    .valid_out (validOut),
    .ready_in  (readyIn),
    .busy_out  (busyOut)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[3];
  int   checkCount = 0;
  int   failCount  = 0;

  // Compare one value and report a mismatch with its name.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key/plaintext and return just after the accepting edge.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
    int n;
    keyIn   = key;
    dataIn  = pt;
    validIn = 1'b1;
    n = 0;
    while (!readyOut && n < 50) begin
      tick();
      n++;
    end
    if (!readyOut) checkOutput("accept_timeout", 128'(readyOut), 128'd1);
    tick();
    validIn = 1'b0;
    keyIn   = '0;
    dataIn  = '0;
  endtask

  // Full encryption of table entry idx, including the output handshake.
  task automatic runVector(input int idx);
    int cyc;
    applyStimulus(vecs[idx].key, vecs[idx].pt);
    tick();
    cyc = 1;
    if (idx == 1)
      checkOutput("round1_state", dut.state_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
    while (!validOut && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput($sformatf("latency_v%0d", idx), 128'(cyc), 128'd10);
    checkOutput($sformatf("ct_v%0d", idx), dataOut, vecs[idx].ct);
    checkOutput($sformatf("busy_done_v%0d", idx), 128'(busyOut), 128'd1);
    checkOutput($sformatf("ready_done_v%0d", idx), 128'(readyOut), 128'd0);
    readyIn = 1'b1;
    tick();
    readyIn = 1'b0;
    checkOutput($sformatf("ready_after_hs_v%0d", idx), 128'(readyOut), 128'd1);
    checkOutput($sformatf("valid_after_hs_v%0d", idx), 128'(validOut), 128'd0);
    checkOutput($sformatf("data_after_hs_v%0d", idx), dataOut, 128'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           cyc;
    int           acc[$];
    logic [127:0] res[$];
    logic         accNow;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{key: 128'h0, pt: 128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst     = 1'b1;
    keyIn   = '0;
    dataIn  = '0;
    validIn = 1'b0;
    readyIn = 1'b0;
    #12;
    checkOutput("reset_ready", 128'(readyOut), 128'd1);
    checkOutput("reset_valid", 128'(validOut), 128'd0);
    checkOutput("reset_data", dataOut, 128'd0);
    checkOutput("reset_busy", 128'(busyOut), 128'd0);
    #10;
    rst = 1'b0;
    tick();

    // Known-answer vectors.
    for (int i = 0; i < 3; i++) runVector(i);

    // Backpressure: result held while ready_in is low, valid_in ignored.
    applyStimulus(vecs[0].key, vecs[0].pt);
    cyc = 0;
    while (!validOut && cyc < 40) begin
      tick();
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      validIn = k[0];
      keyIn   = {$urandom, $urandom, $urandom, $urandom};
      dataIn  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checkOutput($sformatf("bp_data_%0d", k), dataOut, vecs[0].ct);
      checkOutput($sformatf("bp_valid_%0d", k), 128'(validOut), 128'd1);
      checkOutput($sformatf("bp_ready_%0d", k), 128'(readyOut), 128'd0);
    end
    validIn = 1'b0;
    readyIn = 1'b1;
    tick();
    readyIn = 1'b0;
    checkOutput("bp_release_ready", 128'(readyOut), 128'd1);
    checkOutput("bp_release_busy", 128'(busyOut), 128'd0);

    // Back-to-back with valid_in held high and ready_in held high.
    validIn = 1'b1;
    keyIn   = vecs[0].key;
    dataIn  = vecs[0].pt;
    readyIn = 1'b1;
    cyc     = 0;
    while (cyc < 60 && res.size() < 2) begin
      accNow = readyOut && validIn;
      if (validOut) res.push_back(dataOut);
      tick();
      cyc++;
      if (accNow) begin
        acc.push_back(cyc);
        if (acc.size() == 1) begin
          keyIn  = vecs[1].key;
          dataIn = vecs[1].pt;
        end else begin
          validIn = 1'b0;
        end
      end
    end
    validIn = 1'b0;
    readyIn = 1'b0;
    checkOutput("b2b_results", 128'(res.size()), 128'd2);
    checkOutput("b2b_first", (res.size() > 0) ? res[0] : 128'd0, vecs[0].ct);
    checkOutput("b2b_second", (res.size() > 1) ? res[1] : 128'd0, vecs[1].ct);
    checkOutput("b2b_spacing",
                (acc.size() > 1) ? 128'(acc[1] - acc[0]) : 128'd0, 128'd12);

    // Asynchronous reset during round 5.
    applyStimulus(vecs[0].key, vecs[0].pt);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", 128'(readyOut), 128'd1);
    checkOutput("midrst_valid", 128'(validOut), 128'd0);
    checkOutput("midrst_data", dataOut, 128'd0);
    checkOutput("midrst_busy", 128'(busyOut), 128'd0);
    checkOutput("midrst_state", dut.state_q, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    runVector(0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/aes_enc_core.md
# aes_enc_core

Iterative AES-128 encryption engine, the forward-direction counterpart of the decryption datapath in the crypto block. Accepts one 128-bit plaintext and 128-bit key per handshake, runs one AES round per clock with on-the-fly key expansion, and presents the ciphertext on a valid/ready output port. It sits between the crypto command front-end and the result buffer.

## Interface
- NUM_ROUNDS, 10, round count. Only 10 is FIPS-197 AES-128. Legal range is 1..10 and is bounded by the Rcon table.
- clk_in  input  1  system clock, all state on rising edge
- rst_in  input  1  asynchronous, active-high reset
- key_in  input  128  cipher key; [127:120] is key byte 0 (FIPS-197 order)
- data_in  input  128  plaintext; [127:120] is byte 0; state is column-major (bytes 0-3 form column 0)
- valid_in  input  1  plaintext/key valid
- ready_out  output  1  core can accept; high only in IDLE
- data_out  output  128  ciphertext, same byte order as data_in
- valid_out  output  1  ciphertext valid
- ready_in  input  1  downstream accepts ciphertext
- busy_out  output  1  high in ROUND or DONE

## Operation
- States: IDLE, ROUND, DONE. Reset state is IDLE.
- IDLE: ready_out=1. When valid_in&&ready_out at an edge:
  - state_q <= data_in ^ key_in (initial AddRoundKey)
  - rk_q <= key_in
  - rnd_q <= 1
  - go to ROUND.
  - key_in and data_in are don't-care after acceptance.
- ROUND, each edge:
  - next_rk = KeyExpand(rk_q, Rcon[rnd_q]), where w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}, then w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - state_q <= MixColumns(ShiftRows(SubBytes(state_q))) ^ next_rk. MixColumns is omitted when rnd_q==NUM_ROUNDS.
  - rk_q <= next_rk.
  - rnd_q <= rnd_q+1.
  - On the edge where rnd_q==NUM_ROUNDS: go to DONE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- MixColumns arithmetic is GF(2^8) mod x^8+x^4+x^3+x+1. xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0).
- DONE:
  - valid_out=1 and data_out=state_q.
  - Both are held stable while ready_in=0.
  - On valid_out&&ready_in: go to IDLE.
- data_out is driven from state_q only in DONE, and is 0 otherwise.
- busy_out = (state != IDLE).
- valid_in is ignored outside IDLE. There is no queueing.
- Reset mid-operation (any state) clears immediately to IDLE, with rnd_q=0, state_q=0, rk_q=0. The in-flight block is discarded and no partial result appears.

## Timing
- Reset values: ready_out=1, valid_out=0, data_out=0, busy_out=0.
- Latency: acceptance at edge E gives valid_out high after edge E+NUM_ROUNDS (10 cycles).
- Output handshake at edge F gives ready_out high after F. There is no same-cycle accept in DONE.
- Maximum throughput is one block per NUM_ROUNDS+2 = 12 cycles, with ready_in held high.
- Critical path per cycle: SubBytes → ShiftRows → MixColumns → XOR, in parallel with SubWord → key XOR chain (w3' is the deepest).
- Combinational inputs to outputs: none. ready_out, valid_out and data_out are functions of registered state only.

## Structure
- Package aes_pkg holds:
  - the state enum (IDLE/ROUND/DONE)
  - the Rcon constant array
  - functions xtime, mix_column (32-bit), shift_rows (128-bit)
- Sub-module aes_sbox: forward S-box, combinational, parameter NBYTES (default 16), byte-parallel 8-bit lookup.
  - Instance 1 (NBYTES=16) on state_q.
  - Instance 2 (NBYTES=4) on RotWord(w3).
- The core holds the FSM, the registers (state_q, rk_q, rnd_q) and the output muxing.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → data_out 69c4e0d86a7b0430d8cdb78070b4c55a, valid_out exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Also check intermediate state_q after round 1: a49c7ff2689f352b6b5bea43026a5049.
- All-zero key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure: hold ready_in=0 for 5 cycles in DONE → data_out/valid_out stable, ready_out=0, and valid_in pulses are ignored. Release → ready_out=1 on the next cycle.
- Back-to-back: valid_in held high with the C.1 and B vectors, ready_in=1 → two correct results, accepts 12 cycles apart, results in order.
- Reset asserted asynchronously at round 5 → outputs immediately at reset values. A fresh C.1 encryption after deassertion is correct.
